// File: rtl/shared_queue_ctrl_if.sv
// Producer, FIFO and consumer signals of the shared queue controller.
// master is the controller side; slave is the producers/FIFO/consumer side.
interface shared_queue_ctrl_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned REQ_IDX = 2,
  parameter int unsigned WIDTH   = 32
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic [REQ_IDX-1:0]       grant_idx;
  logic [WIDTH-1:0]         q_din;
  logic                     q_enqueue;
  logic                     q_dequeue;
  logic [WIDTH-1:0]         q_dout;
  logic                     q_empty;
  logic                     q_full;
  logic                     out_valid;
  logic [WIDTH-1:0]         out_data;
  logic                     out_ready;

  modport master (
    input  req_valid, req_data, q_dout, q_empty, q_full, out_ready,
    output req_ready, grant_idx, q_din, q_enqueue, q_dequeue, out_valid, out_data
  );

  modport slave (
    output req_valid, req_data, q_dout, q_empty, q_full, out_ready,
    input  req_ready, grant_idx, q_din, q_enqueue, q_dequeue, out_valid, out_data
  );
endinterface

// File: rtl/shared_queue_ctrl.sv
// Shares one single-ported FIFO between NUM_REQ round-robin producers and one
// consumer; one FIFO op per cycle, dequeued words land in a valid/ready register.
module shared_queue_ctrl #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned REQ_IDX = 2,
  parameter int unsigned WIDTH   = 32
) (
  input  logic                clk,
  input  logic                rst,
  shared_queue_ctrl_if.master bus
);

  typedef enum logic {
    OP_ENQ = 1'b0,
    OP_DEQ = 1'b1
  } op_e;

  logic [REQ_IDX-1:0] r_rr_ptr;
  logic               r_rd_inflight;
  op_e                r_last_conflict;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;

  logic [REQ_IDX-1:0] w_rr_ptr_nxt;
  logic               w_rd_inflight_nxt;
  op_e                w_last_conflict_nxt;
  logic               w_out_valid_nxt;
  logic [WIDTH-1:0]   w_out_data_nxt;
  logic [REQ_IDX-1:0] w_winner;
  logic [REQ_IDX-1:0] w_idx;
  logic               w_found;
  logic               w_enq_cand;
  logic               w_deq_cand;
  logic               w_do_enq;
  logic               w_do_deq;
  logic [NUM_REQ-1:0] w_req_ready;

  // Scheduler: round-robin search, enqueue/dequeue choice and next state.
  always_comb begin
    w_winner            = r_rr_ptr;
    w_idx               = r_rr_ptr;
    w_found             = 1'b0;
    w_rr_ptr_nxt        = r_rr_ptr;
    w_last_conflict_nxt = r_last_conflict;
    w_out_valid_nxt     = r_out_valid;
    w_out_data_nxt      = r_out_data;
    w_req_ready         = '0;

    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = r_rr_ptr + REQ_IDX'(k);
      if (!w_found && bus.req_valid[w_idx]) begin
        w_winner = w_idx;
        w_found  = 1'b1;
      end
    end

    w_enq_cand = (|bus.req_valid) && !bus.q_full;
    w_deq_cand = !bus.q_empty && !r_rd_inflight && (!r_out_valid || bus.out_ready);

    // On a conflict, take the op that lost the previous conflict.
    w_do_enq = !rst && w_enq_cand && (!w_deq_cand || (r_last_conflict == OP_DEQ));
    w_do_deq = !rst && w_deq_cand && (!w_enq_cand || (r_last_conflict == OP_ENQ));

    if (w_enq_cand && w_deq_cand)
      w_last_conflict_nxt = w_do_enq ? OP_ENQ : OP_DEQ;

    if (w_do_enq) begin
      w_req_ready[w_winner] = 1'b1;
      w_rr_ptr_nxt          = w_winner + REQ_IDX'(1);
    end

    w_rd_inflight_nxt = w_do_deq;

    if (r_rd_inflight) begin
      w_out_valid_nxt = 1'b1;
      w_out_data_nxt  = bus.q_dout;
    end else if (r_out_valid && bus.out_ready) begin
      w_out_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr        <= '0;
      r_rd_inflight   <= 1'b0;
      r_last_conflict <= OP_ENQ;
      r_out_valid     <= 1'b0;
      r_out_data      <= '0;
    end else begin
      r_rr_ptr        <= w_rr_ptr_nxt;
      r_rd_inflight   <= w_rd_inflight_nxt;
      r_last_conflict <= w_last_conflict_nxt;
      r_out_valid     <= w_out_valid_nxt;
      r_out_data      <= w_out_data_nxt;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.grant_idx = w_winner;
  assign bus.q_din     = bus.req_data[32'(w_winner) * WIDTH +: WIDTH];
  assign bus.q_enqueue = w_do_enq;
  assign bus.q_dequeue = w_do_deq;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;

endmodule

// File: tb/tb_shared_queue_ctrl.sv
// Randomized bench for shared_queue_ctrl: a small FIFO model, a cycle-level
// scheduling reference and a data scoreboard checked at the consumer side.
module tb_shared_queue_ctrl;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned REQ_IDX = 2;
  localparam int unsigned WIDTH   = 32;
  localparam int          FDEPTH  = 4;

  logic clk = 1'b0;
  logic rst;
  logic force_full;

  shared_queue_ctrl_if #(.NUM_REQ(NUM_REQ), .REQ_IDX(REQ_IDX), .WIDTH(WIDTH)) bus ();

  shared_queue_ctrl #(.NUM_REQ(NUM_REQ), .REQ_IDX(REQ_IDX), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // FIFO model: registered dout and registered occupancy-based flags.
  logic [WIDTH-1:0] f_mem [FDEPTH];
  int               f_cnt, f_wr, f_rd;
  logic [WIDTH-1:0] f_dout;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      f_cnt  <= 0;
      f_wr   <= 0;
      f_rd   <= 0;
      f_dout <= '0;
    end else if (bus.q_enqueue && f_cnt < FDEPTH) begin
      f_mem[f_wr] <= bus.q_din;
      f_wr        <= (f_wr + 1) % FDEPTH;
      f_cnt       <= f_cnt + 1;
    end else if (bus.q_dequeue && f_cnt > 0) begin
      f_dout <= f_mem[f_rd];
      f_rd   <= (f_rd + 1) % FDEPTH;
      f_cnt  <= f_cnt - 1;
    end
  end

  assign bus.q_dout  = f_dout;
  assign bus.q_empty = (f_cnt == 0);
  assign bus.q_full  = (f_cnt == FDEPTH) || force_full;

  int n_checks = 0;
  int n_errors = 0;
  logic [WIDTH-1:0] exp_q [$];

  // Reference scheduler state
  int m_rr;
  bit m_inflight, m_out_valid, m_last_deq;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rr        = 0;
    m_inflight  = 1'b0;
    m_out_valid = 1'b0;
    m_last_deq  = 1'b0;
    exp_q.delete();
  endtask

  // Predict this cycle's outputs from the current inputs, compare, then advance.
  task automatic step_check();
    bit enq_c, deq_c, do_enq, do_deq;
    int win;
    logic [NUM_REQ-1:0] exp_rdy;
    logic [WIDTH-1:0] exp_din;
    enq_c  = (bus.req_valid != '0) && !bus.q_full;
    deq_c  = !bus.q_empty && !m_inflight && (!m_out_valid || bus.out_ready);
    do_enq = enq_c && (!deq_c || m_last_deq);
    do_deq = deq_c && (!enq_c || !m_last_deq);
    if (enq_c && deq_c) m_last_deq = do_deq;
    win = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (bus.req_valid[(m_rr + k) % NUM_REQ]) win = (m_rr + k) % NUM_REQ;
    exp_rdy = '0;
    if (do_enq) exp_rdy[win] = 1'b1;
    exp_din = bus.req_data[win*WIDTH +: WIDTH];
    chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    chk("q_enqueue", 64'(bus.q_enqueue), 64'(do_enq));
    chk("q_dequeue", 64'(bus.q_dequeue), 64'(do_deq));
    chk("out_valid", 64'(bus.out_valid), 64'(m_out_valid));
    if (do_enq) begin
      chk("grant_idx", 64'(bus.grant_idx), 64'(win));
      chk("q_din", 64'(bus.q_din), 64'(exp_din));
      exp_q.push_back(exp_din);
      m_rr = (win + 1) % NUM_REQ;
    end
    if (m_inflight) m_out_valid = 1'b1;
    else if (m_out_valid && bus.out_ready) m_out_valid = 1'b0;
    m_inflight = do_deq;
  endtask

  int stall_cnt = 0;

  task automatic drive_random(input bit allow_full);
    bus.req_valid = NUM_REQ'($urandom) & (($urandom_range(0, 1) == 1) ? '1 : NUM_REQ'($urandom));
    for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    force_full = allow_full && ($urandom_range(0, 9) == 0);
    if (stall_cnt > 0) begin
      bus.out_ready = 1'b0;
      stall_cnt--;
    end else if ($urandom_range(0, 11) == 0) begin
      bus.out_ready = 1'b0;
      stall_cnt = $urandom_range(1, 6);
    end else begin
      bus.out_ready = 1'b1;
    end
  endtask

  // Consumer-side monitor: every transfer pops the oldest expected word.
  initial begin
    logic [WIDTH-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("out_data_unexpected", 64'(bus.out_data), 64'hDEAD_BEEF_0000_0000);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 64'(bus.out_data), 64'(e));
        end
      end
    end
  end

  initial begin
    bit hit;
    rst           = 1'b1;
    force_full    = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);

    // Single-word latency from producer 2 into an empty FIFO.
    bus.req_valid = 4'b0100;
    bus.req_data[2*WIDTH +: WIDTH] = 32'hA5A5_0002;
    #1;
    chk("lat_req_ready", 64'(bus.req_ready), 64'b0100);
    step_check();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus.req_valid = '0;
      #1;
      if (k == 1) chk("lat_dequeue", 64'(bus.q_dequeue), 64'd1);
      if (k == 3) begin
        chk("lat_out_valid", 64'(bus.out_valid), 64'd1);
        chk("lat_out_data", 64'(bus.out_data), 64'hA5A5_0002);
      end
      if (k == 4) chk("lat_out_clear", 64'(bus.out_valid), 64'd0);
      step_check();
    end

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      drive_random(1'b1);
      #1 step_check();
    end

    // Reset while a dequeue capture is pending.
    hit = 1'b0;
    for (int c = 0; c < 300 && !hit; c++) begin
      @(negedge clk);
      drive_random(1'b0);
      bus.out_ready = 1'b1;
      stall_cnt = 0;
      #1 step_check();
      hit = m_inflight;
    end
    if (!hit) chk("inflight_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #2;
    bus.req_valid = '1;
    rst = 1'b1;
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_q_enqueue", 64'(bus.q_enqueue), 64'd0);
    chk("rst_q_dequeue", 64'(bus.q_dequeue), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    force_full = 1'b0;
    bus.req_valid = '1;
    #1;
    chk("post_rst_grant", 64'(bus.req_ready), 64'b0001);
    step_check();

    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      drive_random(1'b1);
      #1 step_check();
    end

    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      bus.req_valid = '0;
      bus.out_ready = 1'b1;
      force_full    = 1'b0;
      #1 step_check();
    end
    #3;
    chk("drain_left", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
